// File: rtl/led_matrix_scanner.sv
// LED matrix column scanner with double-buffered frames swapped only at frame boundaries.
// Optional LED_BRIGHTNESS_EN adds a brightness[3:0] input that gates the ON phase (needs DIVIDER >= 4).
//
// state | meaning
// BLANK | all LEDs off between columns (anti-ghosting gap)
// ON    | column x driven from the active frame
module led_matrix_scanner #(
  parameter int N            = 8,
  parameter int DIVIDER      = 12,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N*N-1:0]         cells_in,
  input  logic                   load_valid,
`ifdef LED_BRIGHTNESS_EN
  input  logic [3:0]             brightness,
`endif
  output logic                   load_ready,
  output logic                   frame_done,
  output logic [$clog2(N):0]     x,
  output logic [N-1:0]           cols,
  output logic [N-1:0]           rows
);

  localparam int XW     = $clog2(N) + 1;
  localparam int CW_RAW = (DIVIDER > $clog2(BLANK_CYCLES)) ? DIVIDER : $clog2(BLANK_CYCLES);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] ON_LAST    = CW'((2 ** DIVIDER) - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic [N*N-1:0] active;
  logic [N*N-1:0] shadow;
  logic           shadow_full;
  logic           on_end;
  logic           boundary;
  logic           lit;
  logic [XW-2:0]  xi;
  logic [N-1:0]   row_bits;

  assign load_ready = ~shadow_full;
  assign on_end     = ena && (state == ST_ON) && (cnt == ON_LAST);
  assign boundary   = on_end && (x == X_LAST);
  assign xi         = x[XW-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      x           <= '0;
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (ena) begin
        if (state == ST_BLANK) begin
          if (cnt == BLANK_LAST) begin
            state <= ST_ON;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else if (cnt == ON_LAST) begin
          state <= ST_BLANK;
          cnt   <= '0;
          x     <= (x == X_LAST) ? '0 : x + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // A full shadow blocks loads, so swap and load can never both fire.
      if (boundary && shadow_full) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end else if (load_valid && !shadow_full) begin
        shadow      <= cells_in;
        shadow_full <= 1'b1;
      end
    end
  end

`ifdef LED_BRIGHTNESS_EN
  assign lit = ena && (state == ST_ON) && (cnt[DIVIDER-1 -: 4] < brightness);
`else
  assign lit = ena && (state == ST_ON);
`endif

  always_comb begin
    cols     = '0;
    rows     = '1;
    row_bits = '0;
    if (lit) begin
      cols = N'(1) << xi;
      for (int r = 0; r < N; r++) begin
        row_bits = active[N*r +: N];
        rows[r]  = ~row_bits[xi];
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: loaded frames are queued and retired at frame boundaries.
module tb_led_matrix_scanner;

  localparam int N       = 4;
  localparam int DIV     = 2;
  localparam int BLK     = 2;
  localparam int COL_LEN = BLK + (1 << DIV);
  localparam int FRAME   = N * COL_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] cells_in = '0;
  logic        load_ready;
  logic        frame_done;
  logic [2:0]  x;
  logic [3:0]  cols;
  logic [3:0]  rows;

  int errors = 0;
  int checks = 0;

  // reference model: position inside the frame, displayed frame, pending-frame queue
  int          pos = 0;
  logic [15:0] disp = '0;
  logic [15:0] sb[$];
  logic        fd_exp = 1'b0;

  led_matrix_scanner #(.N(N), .DIVIDER(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cells_in(cells_in), .load_valid(load_valid),
    .load_ready(load_ready), .frame_done(frame_done), .x(x), .cols(cols), .rows(rows)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_rows(input logic [15:0] f, input int c);
    logic [3:0] v;
    for (int r = 0; r < N; r++) v[r] = ~f[N*r + c];
    return v;
  endfunction

  task automatic model_reset();
    pos    = 0;
    disp   = '0;
    fd_exp = 1'b0;
    sb.delete();
  endtask

  // Called at a negedge: compare outputs, drive next inputs, advance the model, wait a cycle.
  task automatic cyc(input logic e, input logic lv, input logic [15:0] d);
    int   col;
    bit   on;
    bit   accept;
    bit   wrap;
    col = pos / COL_LEN;
    on  = (pos % COL_LEN) >= BLK;
    check("x", 32'(x), 32'(col));
    check("frame_done", 32'(frame_done), 32'(fd_exp));
    check("load_ready", 32'(load_ready), 32'(sb.size() == 0));
    check("cols", 32'(cols), (ena && on) ? 32'(1 << col) : 32'h0);
    check("rows", 32'(rows), (ena && on) ? 32'(exp_rows(disp, col)) : 32'hF);
    ena        = e;
    load_valid = lv;
    cells_in   = d;
    accept = lv && (sb.size() == 0);
    wrap   = e && (pos == FRAME - 1);
    fd_exp = wrap;
    if (wrap && sb.size() > 0) disp = sb.pop_front();
    if (accept) sb.push_back(d);
    if (e) pos = (pos + 1) % FRAME;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0);
  endtask

  task automatic wait_pos(input int target);
    for (int i = 0; i < 2 * FRAME && pos != target; i++) cyc(1'b1, 1'b0, 16'h0);
  endtask

  task automatic reset_checks();
    check("rst_cols", 32'(cols), 32'h0);
    check("rst_rows", 32'(rows), 32'hF);
    check("rst_x", 32'(x), 32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h1);
    check("rst_frame_done", 32'(frame_done), 32'h0);
  endtask

  initial begin
    // async reset with no clock edge yet
    #3 rst_n = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // single-pixel frame loaded at cycle 0, swapped at the first boundary
    ena = 1'b1;
    cyc(1'b1, 1'b1, 16'h0001);
    run(2 * FRAME + 4);

    // frame A then load_valid held with frame B
    for (int i = 0; i < 2 * FRAME && sb.size() != 0; i++) cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 16'h8421);
    for (int i = 0; i < FRAME + 3; i++) cyc(1'b1, 1'b1, 16'h0F0F);
    run(2 * FRAME);

    // ena dropped for 10 cycles in the middle of column 2 ON
    wait_pos(2 * COL_LEN + BLK + 1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 16'h0);
    run(FRAME + 4);

    // load lands on the boundary edge while shadow is empty
    for (int i = 0; i < 2 * FRAME && sb.size() != 0; i++) cyc(1'b1, 1'b0, 16'h0);
    wait_pos(FRAME - 1);
    cyc(1'b1, 1'b1, 16'hC3A5);
    run(2 * FRAME + 2);

    // randomized ena / load traffic
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), 16'($urandom));

    // reset mid-scan with a pending shadow frame
    cyc(1'b1, 1'b1, 16'hFFFF);
    run(5);
    #2 rst_n = 1'b0;
    load_valid = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(FRAME + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
